ipsc_current_sequencer: RTL and testbench
=========================================

# ipsc_current_sequencer

Sequencer that evaluates one neuron's total synaptic input current by time-multiplexing a single shared combinational IPSC datapath across NUM_CHANNELS synaptic channels, for example excitatory and inhibitory. On Start it latches the neuron operands, walks the channels, drives the IPSC datapath inputs from a channel-parameter lookup and waits a fixed settle window for the multicycle divide path. It saturating-accumulates each channel's current and presents the sum with a one-cycle Done pulse to the neuron update stage.

## Interface
- INTEGER_WIDTH, 32, integer bits of fixed-point format
- DATA_WIDTH_FRAC, 32, fractional bits
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full word width
- DELTAT_WIDTH, 4, time-step width
- NUM_CHANNELS, 2, channels per neuron (1..16)
- CHSEL_WIDTH, 4, channel index width
- SETTLE_CYCLES, 3, cycles IPSC inputs are held stable before sampling (>=1)

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin evaluation; sampled only in IDLE
- Vmem_in  in  DATA_WIDTH  membrane potential, signed
- DeltaT_in  in  DELTAT_WIDTH  time step
- Taumem_in  in  INTEGER_WIDTH  membrane time constant
- ChannelSel  out  CHSEL_WIDTH  channel-parameter lookup index
- ChannelEin  in  INTEGER_WIDTH  reversal potential for ChannelSel; combinational lookup
- ChannelGin  in  DATA_WIDTH  conductance for ChannelSel; combinational lookup
- IPSC_Ein, IPSC_Vmem, IPSC_gin, IPSC_DeltaT, IPSC_Taumem  out  matching IPSC datapath widths  registered datapath operands
- IPSCIn  in  DATA_WIDTH  datapath result
- ITotal  out  DATA_WIDTH  accumulated current, signed
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse when ITotal is valid
- TauError  out  1  set when Taumem_in==0 at Start; cleared at next accepted Start

## Operation
- States: IDLE, LOAD, SETTLE, ACCUM, FINISH.
- IDLE: on Start, latch Vmem_in, DeltaT_in and Taumem_in into IPSC_Vmem, IPSC_DeltaT and IPSC_Taumem. Clear the accumulator and set ChannelSel=0.
  - If Taumem_in==0: set TauError, go to FINISH. ITotal=0, no channel evaluated.
  - Otherwise: go to LOAD.
- LOAD: register ChannelEin into IPSC_Ein and ChannelGin into IPSC_gin. Load the settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: decrement the counter. Go to ACCUM when the counter is 0.
- ACCUM: acc <= sat(acc + IPSCIn).
  - If ChannelSel==NUM_CHANNELS-1: ITotal <= sat result, go to FINISH.
  - Otherwise: ChannelSel++, go to LOAD.
- FINISH: Done=1 for this cycle only. Go to IDLE.
- Arithmetic: the sum is computed at DATA_WIDTH+1 bits and clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. The accumulator is clamped after every add, not only at the end.
- Start while Busy is ignored. Input changes after Start are ignored, because operands are latched. ChannelEin and ChannelGin are sampled only in LOAD.
- ITotal holds its value until the next ACCUM-to-FINISH transition or the next TauError FINISH.

## Timing
- Reset (any state, including mid-evaluation) sets:
  - state IDLE
  - ChannelSel, all IPSC_* outputs, ITotal and the accumulator to 0
  - Busy, Done and TauError to 0
- No Done is produced for an evaluation aborted by Reset.
- With Start sampled at edge 0:
  - channel k is in LOAD at cycle 1+k(SETTLE_CYCLES+2)
  - ACCUM for channel k is at cycle (k+1)(SETTLE_CYCLES+2)
  - Done is high in cycle NUM_CHANNELS(SETTLE_CYCLES+2)+1
- Defaults give Done at cycle 11. A TauError run gives Done at cycle 1.
- Busy rises the cycle after Start and falls the cycle after Done. Start is first accepted again in the cycle after Done.
- IPSC_* outputs are stable from the LOAD edge through ACCUM. This gives the datapath a SETTLE_CYCLES+1 cycle multicycle path.

## Configuration
- IPSC_SKIP_ZERO_GIN_EN defined: in LOAD, if ChannelGin==0, skip SETTLE and ACCUM. That channel contributes 0.
  - Not the last channel: ChannelSel++ and stay in LOAD.
  - Last channel: ITotal <= acc, go to FINISH.
  - Latency shrinks by SETTLE_CYCLES+1 per skipped channel.
- Undefined: every channel takes the full LOAD/SETTLE/ACCUM path regardless of gin.

## Test plan
- Defaults, bench stub drives IPSCIn=+3.5 for ChannelSel 0 and -1.25 for ChannelSel 1; Start -> Done in cycle 11, ITotal=2.25 (0x0000_0002_4000_0000), Busy high cycles 1-11.
- Stub returns 0x7FFF_FFFF_0000_0000 for both channels -> ITotal=0x7FFF_FFFF_FFFF_FFFF (positive clamp); repeat with 0x8000_0001_0000_0000 twice -> ITotal=0x8000_0000_0000_0000.
- Taumem_in=0 at Start -> TauError=1, Done in cycle 1, ITotal=0, ChannelSel stays 0; next Start with Taumem_in=10 clears TauError.
- Reset asserted at cycle 6 of an evaluation -> all outputs 0 next cycle, no Done for 20 cycles; Start pulses while Busy are ignored, with Done exactly once per accepted Start.
- Vmem_in changed from -65.0 to 0 one cycle after Start -> IPSC_Vmem stays -65.0 throughout; ChannelEin/ChannelGin changed outside LOAD are not reflected in IPSC_Ein/IPSC_gin.
- IPSC_SKIP_ZERO_GIN_EN defined, ChannelGin=0 for channel 0 -> Done in cycle 7, ITotal equals the channel-1 stub value only.

Source files
------------

// File: rtl/ipsc_current_sequencer.sv
// Time-multiplexes one shared IPSC datapath across a neuron's synaptic channels and saturating-accumulates the total current.
// Optional feature macro: IPSC_SKIP_ZERO_GIN_EN (skip channels whose conductance is zero).
module ipsc_current_sequencer #(
    parameter int unsigned INTEGER_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH_FRAC = 32,
    parameter int unsigned DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int unsigned DELTAT_WIDTH    = 4,
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned CHSEL_WIDTH     = 4,
    parameter int unsigned SETTLE_CYCLES   = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [DATA_WIDTH-1:0]    Vmem_in,
    input  logic [DELTAT_WIDTH-1:0]  DeltaT_in,
    input  logic [INTEGER_WIDTH-1:0] Taumem_in,
    output logic [CHSEL_WIDTH-1:0]   ChannelSel,
    input  logic [INTEGER_WIDTH-1:0] ChannelEin,
    input  logic [DATA_WIDTH-1:0]    ChannelGin,
    output logic [INTEGER_WIDTH-1:0] IPSC_Ein,
    output logic [DATA_WIDTH-1:0]    IPSC_Vmem,
    output logic [DATA_WIDTH-1:0]    IPSC_gin,
    output logic [DELTAT_WIDTH-1:0]  IPSC_DeltaT,
    output logic [INTEGER_WIDTH-1:0] IPSC_Taumem,
    input  logic [DATA_WIDTH-1:0]    IPSCIn,
    output logic [DATA_WIDTH-1:0]    ITotal,
    output logic                     Busy,
    output logic                     Done,
    output logic                     TauError
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_ACCUM,
        S_FINISH
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        settle_cnt;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH:0]     sum_wide;
    logic [DATA_WIDTH-1:0]   sum_sat;
    logic                    last_ch;

    // One extra bit of headroom; clamp when the two top bits disagree.
    always_comb begin
        sum_wide = {acc[DATA_WIDTH-1], acc} + {IPSCIn[DATA_WIDTH-1], IPSCIn};
        sum_sat  = sum_wide[DATA_WIDTH-1:0];
        if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
            sum_sat = sum_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    assign last_ch = (ChannelSel == CHSEL_WIDTH'(NUM_CHANNELS - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            acc         <= '0;
            ChannelSel  <= '0;
            IPSC_Ein    <= '0;
            IPSC_Vmem   <= '0;
            IPSC_gin    <= '0;
            IPSC_DeltaT <= '0;
            IPSC_Taumem <= '0;
            ITotal      <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            TauError    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        IPSC_Vmem   <= Vmem_in;
                        IPSC_DeltaT <= DeltaT_in;
                        IPSC_Taumem <= Taumem_in;
                        acc         <= '0;
                        ChannelSel  <= '0;
                        Busy        <= 1'b1;
                        if (Taumem_in == '0) begin
                            TauError <= 1'b1;
                            ITotal   <= '0;
                            Done     <= 1'b1;
                            state    <= S_FINISH;
                        end else begin
                            TauError <= 1'b0;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    IPSC_Ein   <= ChannelEin;
                    IPSC_gin   <= ChannelGin;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                    state      <= S_SETTLE;
`ifdef IPSC_SKIP_ZERO_GIN_EN
                    // Zero conductance contributes nothing; move straight on.
                    if (ChannelGin == '0) begin
                        if (last_ch) begin
                            ITotal <= acc;
                            Done   <= 1'b1;
                            state  <= S_FINISH;
                        end else begin
                            ChannelSel <= ChannelSel + CHSEL_WIDTH'(1);
                            state      <= S_LOAD;
                        end
                    end
`endif
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_ACCUM;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_ACCUM: begin
                    acc <= sum_sat;
                    if (last_ch) begin
                        ITotal <= sum_sat;
                        Done   <= 1'b1;
                        state  <= S_FINISH;
                    end else begin
                        ChannelSel <= ChannelSel + CHSEL_WIDTH'(1);
                        state      <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipsc_current_sequencer.sv
// Directed bench for ipsc_current_sequencer: vector table of full evaluations plus hand-written reset/Start/latching sequences.
module tb_ipsc_current_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [63:0] Vmem_in;
    logic [3:0]  DeltaT_in;
    logic [31:0] Taumem_in;
    logic [3:0]  ChannelSel;
    logic [31:0] ChannelEin;
    logic [63:0] ChannelGin;
    logic [31:0] IPSC_Ein;
    logic [63:0] IPSC_Vmem;
    logic [63:0] IPSC_gin;
    logic [3:0]  IPSC_DeltaT;
    logic [31:0] IPSC_Taumem;
    logic [63:0] IPSCIn;
    logic [63:0] ITotal;
    logic        Busy;
    logic        Done;
    logic        TauError;

    logic [63:0] stub [2];
    logic [31:0] ein_tab [2];
    logic [63:0] gin_tab [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    // Combinational channel-parameter lookup and IPSC datapath stub.
    assign IPSCIn     = stub[ChannelSel[0]];
    assign ChannelEin = ein_tab[ChannelSel[0]];
    assign ChannelGin = gin_tab[ChannelSel[0]];

    ipsc_current_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Vmem_in     (Vmem_in),
        .DeltaT_in   (DeltaT_in),
        .Taumem_in   (Taumem_in),
        .ChannelSel  (ChannelSel),
        .ChannelEin  (ChannelEin),
        .ChannelGin  (ChannelGin),
        .IPSC_Ein    (IPSC_Ein),
        .IPSC_Vmem   (IPSC_Vmem),
        .IPSC_gin    (IPSC_gin),
        .IPSC_DeltaT (IPSC_DeltaT),
        .IPSC_Taumem (IPSC_Taumem),
        .IPSCIn      (IPSCIn),
        .ITotal      (ITotal),
        .Busy        (Busy),
        .Done        (Done),
        .TauError    (TauError)
    );

    typedef struct {
        string       name;
        logic [63:0] vmem;
        logic [3:0]  deltat;
        logic [31:0] taumem;
        logic [63:0] stub0;
        logic [63:0] stub1;
        logic [63:0] gin0;
        logic [63:0] exp_itotal;
        int          exp_done;
        logic        exp_tauerr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Start one evaluation, scramble the inputs right after it is sampled, and track Done/Busy per cycle.
    task automatic run_vec(input vec_t v);
        int done_cyc;
        int ndone;
        int bad_busy;
        Vmem_in    = v.vmem;
        DeltaT_in  = v.deltat;
        Taumem_in  = v.taumem;
        stub[0]    = v.stub0;
        stub[1]    = v.stub1;
        gin_tab[0] = v.gin0;
        gin_tab[1] = 64'h0000_0000_8000_0000;
        ein_tab[0] = 32'hFFFF_FFB0;
        ein_tab[1] = 32'h0000_0000;
        Start      = 1'b1;
        tick();
        Start     = 1'b0;
        Vmem_in   = 64'h0;
        DeltaT_in = 4'hF;
        Taumem_in = 32'h1234_5678;
        done_cyc  = 0;
        ndone     = 0;
        bad_busy  = 0;
        for (int c = 1; c <= v.exp_done + 4; c++) begin
            if (Done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (Busy !== (c <= v.exp_done)) bad_busy++;
            tick();
        end
        check({v.name, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        check({v.name, " done_count"}, 64'(ndone), 64'd1);
        check({v.name, " busy_profile_errors"}, 64'(bad_busy), 64'd0);
        check({v.name, " itotal"}, ITotal, v.exp_itotal);
        check({v.name, " tauerror"}, 64'(TauError), 64'(v.exp_tauerr));
        check({v.name, " ipsc_vmem"}, IPSC_Vmem, v.vmem);
        check({v.name, " ipsc_deltat"}, 64'(IPSC_DeltaT), 64'(v.deltat));
        check({v.name, " ipsc_taumem"}, 64'(IPSC_Taumem), 64'(v.taumem));
        if (v.exp_tauerr) check({v.name, " chansel"}, 64'(ChannelSel), 64'd0);
    endtask

    initial begin
        int ndone;
        int c_done;

        vecs[0] = '{"mixed",    64'hFFFF_FFBF_0000_0000, 4'd1, 32'd20,
                    64'h0000_0003_8000_0000, 64'hFFFF_FFFE_C000_0000, 64'h1_0000_0000,
                    64'h0000_0002_4000_0000, 11, 1'b0};
        vecs[1] = '{"pos_clamp", 64'h0000_0001_0000_0000, 4'd2, 32'd5,
                    64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h1_0000_0000,
                    64'h7FFF_FFFF_FFFF_FFFF, 11, 1'b0};
        vecs[2] = '{"neg_clamp", 64'h0000_0002_0000_0000, 4'd3, 32'd7,
                    64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000, 64'h1_0000_0000,
                    64'h8000_0000_0000_0000, 11, 1'b0};
        vecs[3] = '{"tau_zero", 64'hFFFF_FFBF_0000_0000, 4'd4, 32'd0,
                    64'h0000_0003_8000_0000, 64'h0000_0001_0000_0000, 64'h1_0000_0000,
                    64'h0, 1, 1'b1};
        vecs[4] = '{"tau_clear", 64'h0000_0000_4000_0000, 4'd5, 32'd10,
                    64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 64'h1_0000_0000,
                    64'h0000_0003_0000_0000, 11, 1'b0};
        vecs[5] = '{"neg_plain", 64'hFFFF_FFFF_8000_0000, 4'd6, 32'd3,
                    64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFD_8000_0000, 64'h1_0000_0000,
                    64'hFFFF_FFFC_8000_0000, 11, 1'b0};
`ifdef IPSC_SKIP_ZERO_GIN_EN
        vecs[6] = '{"gin0_zero", 64'h0000_0000_0000_0000, 4'd7, 32'd9,
                    64'h0000_0005_0000_0000, 64'h0000_0001_8000_0000, 64'h0,
                    64'h0000_0001_8000_0000, 7, 1'b0};
`else
        vecs[6] = '{"gin0_zero", 64'h0000_0000_0000_0000, 4'd7, 32'd9,
                    64'h0000_0005_0000_0000, 64'h0000_0001_8000_0000, 64'h0,
                    64'h0000_0006_8000_0000, 11, 1'b0};
`endif

        Reset      = 1'b1;
        Start      = 1'b0;
        Vmem_in    = 64'h0;
        DeltaT_in  = 4'h0;
        Taumem_in  = 32'h0;
        stub[0]    = 64'h0;
        stub[1]    = 64'h0;
        ein_tab[0] = 32'h0;
        ein_tab[1] = 32'h0;
        gin_tab[0] = 64'h0;
        gin_tab[1] = 64'h0;
        repeat (3) tick();
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset tauerror", 64'(TauError), 64'd0);
        check("reset itotal", ITotal, 64'h0);
        check("reset chansel", 64'(ChannelSel), 64'd0);
        check("reset ipsc_vmem", IPSC_Vmem, 64'h0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Channel parameters changed after LOAD must not reach the IPSC operands.
        Vmem_in    = 64'hFFFF_FFBF_0000_0000;
        DeltaT_in  = 4'd1;
        Taumem_in  = 32'd10;
        stub[0]    = 64'h0000_0001_0000_0000;
        stub[1]    = 64'h0000_0001_0000_0000;
        ein_tab[0] = 32'hFFFF_FFB5;
        gin_tab[0] = 64'h0000_0000_2000_0000;
        gin_tab[1] = 64'h0000_0000_3000_0000;
        Start      = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        ein_tab[0] = 32'h0000_0011;
        gin_tab[0] = 64'h0000_0007_0000_0000;
        tick();
        tick();
        check("latch ipsc_ein ch0", 64'(IPSC_Ein), 64'h0000_0000_FFFF_FFB5);
        check("latch ipsc_gin ch0", IPSC_gin, 64'h0000_0000_2000_0000);
        repeat (3) tick();
        check("ch1 loaded ipsc_gin", IPSC_gin, 64'h0000_0000_3000_0000);
        check("ch1 chansel", 64'(ChannelSel), 64'd1);
        repeat (8) tick();
        check("latch run itotal", ITotal, 64'h0000_0002_0000_0000);

        // Reset in cycle 6 of an evaluation aborts it with no Done.
        Taumem_in = 32'd10;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        Reset = 1'b1;
        tick();
        check("midreset busy", 64'(Busy), 64'd0);
        check("midreset done", 64'(Done), 64'd0);
        check("midreset itotal", ITotal, 64'h0);
        check("midreset chansel", 64'(ChannelSel), 64'd0);
        check("midreset ipsc_gin", IPSC_gin, 64'h0);
        check("midreset ipsc_taumem", 64'(IPSC_Taumem), 64'd0);
        Reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (Done === 1'b1) ndone++;
            tick();
        end
        check("midreset no done", 64'(ndone), 64'd0);

        // Start pulses while busy (including the Done cycle) are ignored.
        stub[0] = 64'h0000_0003_8000_0000;
        stub[1] = 64'hFFFF_FFFE_C000_0000;
        Start   = 1'b1;
        tick();
        Start  = 1'b0;
        ndone  = 0;
        c_done = 0;
        for (int c = 1; c <= 28; c++) begin
            Start = (c == 3 || c == 8 || c == 11);
            if (Done === 1'b1) begin
                ndone++;
                if (c_done == 0) c_done = c;
            end
            tick();
        end
        Start = 1'b0;
        check("busy start done_count", 64'(ndone), 64'd1);
        check("busy start done_cycle", 64'(c_done), 64'd11);
        check("busy start itotal", ITotal, 64'h0000_0002_4000_0000);
        check("busy start idle", 64'(Busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
